mbist_controller: RTL
=====================

Name: mbist_controller

Overview:
- March-style MBIST sequencer for one small SRAM.
- Steps the background-pattern selector through patterns 0..5. For each pattern it writes the pattern to every address, then reads every address back and compares against the same pattern.
- The pattern decoder sits beside it: it receives pat_sel and returns pat_data combinationally.
- Reports busy/done/pass plus first-failure diagnostics to the test access logic.

Parameters:
- ADDR_W, 4, memory address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, memory/pattern width; must match the decoder output.
- NUM_PAT, 6, number of background patterns; pat_sel runs 0..NUM_PAT-1.
- STOP_ON_FAIL, 0, when 1 the controller stops at the first mismatch.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin the test; sampled only in IDLE or DONE.
- pat_sel  out  3  pattern index to the decoder.
- pat_data  in  DATA_W  decoder output; used as write data and expected data.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data; equals pat_data combinationally.
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_re.
- busy  out  1  high from the first WRITE cycle through the final FLUSH.
- done  out  1  high in DONE, held until the next start or rst.
- pass  out  1  valid when done; 1 means zero mismatches.
- fail_cnt  out  8  mismatch count, saturates at 255.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_pat  out  3  pat_sel value at the first mismatch.

Behaviour:
- Reset: state = IDLE. pat_sel, mem_addr, fail_cnt, fail_addr, fail_pat = 0. mem_we, mem_re, busy, done, pass = 0. Reset in any state aborts immediately; no further memory accesses occur.
- States: IDLE, WRITE, READ, FLUSH, DONE.
- IDLE/DONE + start=1: on that edge clear fail_cnt/fail_addr/fail_pat, clear done, set pat_sel=0 and mem_addr=0, go to WRITE. Without start, the state holds.
- WRITE: mem_we=1, mem_re=0, busy=1. mem_addr increments each cycle. Last address (DEPTH-1) -> READ with mem_addr wrapping to 0.
- READ: mem_re=1, mem_we=0. mem_addr increments each cycle. Last address -> FLUSH.
- FLUSH: no memory access, busy=1. Exists only to compare the final read.
  - If pat_sel == NUM_PAT-1, go to DONE.
  - Otherwise increment pat_sel, set mem_addr=0, go to WRITE.
- Compare pipeline: one register stage holds rd_valid and rd_addr from the READ cycle. In the following cycle (READ or FLUSH), when rd_valid=1, compare mem_rdata against pat_data. pat_sel is constant across a READ phase plus its FLUSH, so pat_data is the correct expected value.
- On mismatch:
  - fail_cnt increments, saturating at 255.
  - If fail_cnt was 0, capture fail_addr = rd_addr and fail_pat = pat_sel.
  - If STOP_ON_FAIL=1, go to DONE on the next edge, whatever the current state.
- DONE: busy=0, done=1, pass = (fail_cnt==0). mem_we and mem_re are 0.
- start while busy: ignored.
- start held high in DONE restarts the test, one restart per sampled edge in DONE.
- Timing: with STOP_ON_FAIL=0, busy lasts NUM_PAT*(2*DEPTH+1) cycles. That is 198 cycles for the defaults. done rises on the edge after the last FLUSH cycle.
- Address wrap: mem_addr is ADDR_W wide. DEPTH-1 -> 0 is the only wrap and happens only at phase boundaries.
- pat_sel never exceeds NUM_PAT-1, so the decoder's default (X) entry is never selected.

Test Plan:
- Fault-free memory model, start pulse -> busy high for 198 cycles. Every address is written then read for each pattern 0..5, in that order. Write data per pattern is AA, 55, F0, 0F, 00, FF. Then done=1, pass=1, fail_cnt=0.
- Stuck-at-1 on bit 0 of address 5 -> first mismatch on pattern 0 (wrote AA, read AB). fail_addr=5, fail_pat=0. Further mismatches on patterns 2 and 4. Final fail_cnt=3, pass=0.
- Same fault with STOP_ON_FAIL=1 -> done asserted 2 cycles after the address-5 read of pattern 0. fail_cnt=1, no further memory accesses.
- rst asserted on the 40th busy cycle -> next cycle state=IDLE. All outputs at reset values; mem_we=mem_re=0.
- start pulsed at busy cycles 10 and 100 -> both ignored; completion still at 198 cycles.
- start in DONE after a failing run -> fail_cnt/fail_addr/fail_pat cleared and done dropped. A rerun on fault-free memory ends with pass=1.

Source files
------------

// File: rtl/mbist_controller.sv
// March-style MBIST sequencer: writes each background pattern to every
// address, reads it back, compares and records first-failure diagnostics.
module mbist_controller #(
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned NUM_PAT      = 6,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [2:0]        pat_sel,
    input  logic [DATA_W-1:0] pat_data,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        fail_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_pat
);

    localparam int unsigned       DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        LAST_PAT  = 3'(NUM_PAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [2:0]          r_pat_sel;
    logic                r_mem_we;
    logic                r_mem_re;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [7:0]          r_fail_cnt;
    logic [ADDR_W-1:0]   r_fail_addr;
    logic [2:0]          r_fail_pat;
    logic                r_rd_valid;
    logic [ADDR_W-1:0]   r_rd_addr;

    logic                w_cmp_en;
    logic                w_mismatch;
    logic                w_stop;
    logic [7:0]          w_fail_cnt_nxt;

    // Compare the read issued last cycle; only meaningful while still reading/flushing
    assign w_cmp_en       = r_rd_valid && ((r_state == S_READ) || (r_state == S_FLUSH));
    assign w_mismatch     = w_cmp_en && (mem_rdata != pat_data);
    assign w_stop         = STOP_ON_FAIL && w_mismatch;
    assign w_fail_cnt_nxt = (w_mismatch && (r_fail_cnt != 8'hFF)) ? r_fail_cnt + 8'd1 : r_fail_cnt;

    assign pat_sel   = r_pat_sel;
    assign mem_we    = r_mem_we;
    assign mem_re    = r_mem_re;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = pat_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_cnt  = r_fail_cnt;
    assign fail_addr = r_fail_addr;
    assign fail_pat  = r_fail_pat;

    // Sequencer state, registered outputs, compare pipeline and failure log
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pat_sel   <= 3'd0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_addr  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_cnt  <= 8'd0;
            r_fail_addr <= '0;
            r_fail_pat  <= 3'd0;
            r_rd_valid  <= 1'b0;
            r_rd_addr   <= '0;
        end else begin
            r_rd_valid <= (r_state == S_READ);
            r_rd_addr  <= r_mem_addr;
            r_fail_cnt <= w_fail_cnt_nxt;
            if (w_mismatch && (r_fail_cnt == 8'd0)) begin
                r_fail_addr <= r_rd_addr;
                r_fail_pat  <= r_pat_sel;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_WRITE;
                        r_pat_sel   <= 3'd0;
                        r_mem_addr  <= '0;
                        r_mem_we    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_fail_cnt  <= 8'd0;
                        r_fail_addr <= '0;
                        r_fail_pat  <= 3'd0;
                    end
                end
                S_WRITE: begin
                    r_mem_addr <= r_mem_addr + ADDR_W'(1);
                    if (r_mem_addr == LAST_ADDR) begin
                        r_state  <= S_READ;
                        r_mem_we <= 1'b0;
                        r_mem_re <= 1'b1;
                    end
                end
                S_READ: begin
                    r_mem_addr <= r_mem_addr + ADDR_W'(1);
                    if (r_mem_addr == LAST_ADDR) begin
                        r_state  <= S_FLUSH;
                        r_mem_re <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (r_pat_sel == LAST_PAT) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_fail_cnt_nxt == 8'd0);
                    end else begin
                        r_state    <= S_WRITE;
                        r_pat_sel  <= r_pat_sel + 3'd1;
                        r_mem_addr <= '0;
                        r_mem_we   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Early abort on the first mismatch overrides any phase transition
            if (w_stop) begin
                r_state  <= S_DONE;
                r_mem_we <= 1'b0;
                r_mem_re <= 1'b0;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
                r_pass   <= 1'b0;
            end
        end
    end

endmodule
